// File: rtl/hwpe_stream_traffic_sink_if.sv
// hwpe_stream_intf_stream: valid/ready stream link with a byte strobe.
//   valid  : source has a beat on data/strb
//   ready  : sink accepts the beat this cycle
//   data   : DATA_WIDTH-bit payload
//   strb   : one enable bit per data byte
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_traffic_sink.sv
// hwpe_stream_traffic_sink: terminates a stream link, applies LFSR-driven
// backpressure, counts a programmed number of beats and folds the
// strobe-masked data of every beat into a 32-bit rotating-XOR signature.
//
// Ports:
//   clk_i         clock
//   clear_i       synchronous active-high reset
//   enable_i      global enable; low freezes FSM, counters and LFSR
//   start_i       start pulse, honoured in IDLE and DONE
//   len_i         number of beats to consume, latched on start
//   force_ready_i ignore LFSR stalls while running
//   data_i        incoming stream (sink side)
//   busy_o        high in RUN
//   done_o        high in DONE
//   beat_cnt_o    handshakes completed in the current run
//   signature_o   running signature
//   strb_err_o    sticky: a beat was accepted with an all-zero strobe
//
// state | meaning
// IDLE  | waiting for start, ready low
// RUN   | consuming beats under LFSR backpressure
// DONE  | len beats consumed, outputs held, ready low
module hwpe_stream_traffic_sink #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned CNT_WIDTH    = 16,
  parameter logic [7:0]  STALL_THRESH = 8'd0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 clear_i,
  input  logic                 enable_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic                 force_ready_i,
  hwpe_stream_intf_stream.sink data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] beat_cnt_o,
  output logic [31:0]          signature_o,
  output logic                 strb_err_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned NCHUNK = (DATA_WIDTH + 31) / 32;
  localparam int unsigned PAD_W  = NCHUNK * 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] len_q, len_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          sig_q, sig_d;
  logic                 err_q, err_d;
  logic [15:0]          lfsr_q, lfsr_d;

  logic                  stall;
  logic                  ready;
  logic                  lfsr_fb;
  logic [DATA_WIDTH-1:0] masked;
  logic [PAD_W-1:0]      padded;
  logic [31:0]           fold;

  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // A zero threshold would otherwise be a comparison that is always false.
  if (STALL_THRESH == 8'd0) begin : g_no_stall
    assign stall = 1'b0;
  end else begin : g_stall
    assign stall = (lfsr_q[7:0] < STALL_THRESH);
  end

  always_comb begin
    masked = '0;
    for (int b = 0; b < STRB_W; b++) begin
      masked[b*8 +: 8] = data_i.strb[b] ? data_i.data[b*8 +: 8] : 8'h00;
    end
  end

  assign padded = PAD_W'(masked);

  always_comb begin
    fold = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      fold = fold ^ padded[c*32 +: 32];
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    err_d   = err_q;
    lfsr_d  = lfsr_q;
    ready   = 1'b0;
    if (enable_i) begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            len_d   = len_i;
            cnt_d   = '0;
            sig_d   = '0;
            err_d   = 1'b0;
            state_d = (len_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          lfsr_d = {lfsr_q[14:0], lfsr_fb};
          ready  = force_ready_i | ~stall;
          if (ready && data_i.valid) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            sig_d = {sig_q[30:0], sig_q[31]} ^ fold;
            if (data_i.strb == '0) begin
              err_d = 1'b1;
            end
            if (cnt_d == len_q) begin
              state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
      err_q   <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      err_q   <= err_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign data_i.ready = ready;
  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign beat_cnt_o   = cnt_q;
  assign signature_o  = sig_q;
  assign strb_err_o   = err_q;

endmodule

// File: tb/tb_hwpe_stream_traffic_sink.sv
module tb_hwpe_stream_traffic_sink;

  localparam logic [7:0]  THRESH = 8'd128;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk_i = 1'b0;
  logic clear = 1'b1;
  logic enable = 1'b1;
  logic start = 1'b0;
  logic force_ready = 1'b0;
  logic [15:0] len_i = '0;
  logic busy_o, done_o, strb_err_o;
  logic [15:0] beat_cnt_o;
  logic [31:0] signature_o;

  logic start_w = 1'b0;
  logic [15:0] len_w = '0;
  logic busy_w, done_w, err_w;
  logic [15:0] cnt_w;
  logic [31:0] sig_w;

  int checks = 0;
  int errors = 0;
  int run_cyc = 0;
  int stall_cyc = 0;

  typedef struct {
    logic [15:0] cnt;
    logic [31:0] sig;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] m_sig = '0;
  logic [15:0] m_cnt = '0;
  logic        m_err = 1'b0;
  logic [15:0] m_lfsr = SEED;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) s32 ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(80)) sw ();

  always #5 clk_i = ~clk_i;

  hwpe_stream_traffic_sink #(
    .DATA_WIDTH(32), .CNT_WIDTH(16), .STALL_THRESH(THRESH), .LFSR_SEED(SEED)
  ) dut (
    .clk_i(clk_i), .clear_i(clear), .enable_i(enable), .start_i(start),
    .len_i(len_i), .force_ready_i(force_ready), .data_i(s32),
    .busy_o(busy_o), .done_o(done_o), .beat_cnt_o(beat_cnt_o),
    .signature_o(signature_o), .strb_err_o(strb_err_o)
  );

  hwpe_stream_traffic_sink #(
    .DATA_WIDTH(80), .CNT_WIDTH(16), .STALL_THRESH(8'd0), .LFSR_SEED(SEED)
  ) dut_w (
    .clk_i(clk_i), .clear_i(clear), .enable_i(enable), .start_i(start_w),
    .len_i(len_w), .force_ready_i(force_ready), .data_i(sw),
    .busy_o(busy_w), .done_o(done_w), .beat_cnt_o(cnt_w),
    .signature_o(sig_w), .strb_err_o(err_w)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fold32(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? d[b*8 +: 8] : 8'h00;
    return r;
  endfunction

  // Monitor: ready against an independent LFSR model, and scoreboard pops
  // on every observed handshake.
  always begin : mon
    logic hs, run_c, rdy_exp;
    exp_t e;
    @(negedge clk_i);
    hs      = s32.valid & s32.ready & ~clear;
    run_c   = busy_o & enable & ~clear;
    rdy_exp = run_c & (force_ready | (m_lfsr[7:0] >= THRESH));
    if (!clear) chk("ready", 64'(s32.ready), 64'(rdy_exp));
    if (run_c) begin
      run_cyc++;
      if (!s32.ready) stall_cyc++;
    end
    @(posedge clk_i);
    if (clear) m_lfsr = SEED;
    else if (run_c) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    #1;
    if (hs) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat actual=handshake expected=none t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("beat_cnt", 64'(beat_cnt_o), 64'(e.cnt));
        chk("signature", 64'(signature_o), 64'(e.sig));
        chk("strb_err", 64'(strb_err_o), 64'(e.err));
      end
    end
  end

  task automatic do_start(input logic [15:0] len);
    @(negedge clk_i);
    start = 1'b1;
    len_i = len;
    @(posedge clk_i);
    #1;
    start = 1'b0;
    m_sig = '0;
    m_cnt = '0;
    m_err = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] s);
    int n;
    logic hs;
    m_sig = {m_sig[30:0], m_sig[31]} ^ fold32(d, s);
    m_cnt = m_cnt + 16'd1;
    m_err = m_err | (s == 4'h0);
    exp_q.push_back('{cnt: m_cnt, sig: m_sig, err: m_err});
    s32.valid = 1'b1;
    s32.data  = d;
    s32.strb  = s;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 200) begin
      @(negedge clk_i);
      hs = s32.ready;
      @(posedge clk_i);
      #1;
      n++;
    end
    if (!hs) chk("beat_timeout", 64'(n), 64'(0));
  endtask

  task automatic wide_beat(input logic [79:0] d);
    int n;
    logic hs;
    sw.valid = 1'b1;
    sw.data  = d;
    sw.strb  = '1;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 20) begin
      @(negedge clk_i);
      hs = sw.ready;
      @(posedge clk_i);
      #1;
      n++;
    end
    sw.valid = 1'b0;
    if (!hs) chk("wide_timeout", 64'(n), 64'(0));
  endtask

  initial begin : watchdog
    #400000;
    errors++;
    $display("FAIL watchdog actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : stim
    logic [15:0] c0;
    logic [15:0] l0;
    s32.valid = 1'b0; s32.data = '0; s32.strb = '0;
    sw.valid = 1'b0; sw.data = '0; sw.strb = '0;
    repeat (3) @(posedge clk_i);
    #1;
    clear = 1'b0;

    // reset state
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_cnt", 64'(beat_cnt_o), 64'(0));
    chk("rst_sig", 64'(signature_o), 64'(0));
    chk("rst_err", 64'(strb_err_o), 64'(0));
    chk("rst_ready", 64'(s32.ready), 64'(0));
    chk("rst_lfsr", 64'(dut.lfsr_q), 64'(16'hACE1));

    // basic signature: expected 0x1 then 0x0
    force_ready = 1'b1;
    do_start(16'd2);
    chk("start_busy", 64'(busy_o), 64'(1));
    send_beat(32'h0000_0001, 4'hF);
    chk("basic_sig1", 64'(signature_o), 64'(32'h0000_0001));
    send_beat(32'h0000_0002, 4'hF);
    s32.valid = 1'b0;
    chk("basic_sig2", 64'(signature_o), 64'(32'h0000_0000));
    chk("basic_done", 64'(done_o), 64'(1));
    chk("basic_busy", 64'(busy_o), 64'(0));
    chk("basic_cnt", 64'(beat_cnt_o), 64'(2));
    chk("basic_ready_low", 64'(s32.ready), 64'(0));

    // strobe masking and sticky error
    do_start(16'd1);
    send_beat(32'hFFFF_FFFF, 4'b0011);
    s32.valid = 1'b0;
    chk("mask_sig", 64'(signature_o), 64'(32'h0000_FFFF));
    do_start(16'd1);
    send_beat(32'hFFFF_FFFF, 4'b0000);
    s32.valid = 1'b0;
    chk("zero_strb_sig", 64'(signature_o), 64'(0));
    chk("zero_strb_err", 64'(strb_err_o), 64'(1));

    // zero length: straight to DONE, clears the sticky error
    do_start(16'd0);
    chk("len0_done", 64'(done_o), 64'(1));
    chk("len0_busy", 64'(busy_o), 64'(0));
    chk("len0_err_clr", 64'(strb_err_o), 64'(0));
    s32.valid = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    s32.valid = 1'b0;
    chk("len0_cnt", 64'(beat_cnt_o), 64'(0));

    // start ignored in RUN
    do_start(16'd4);
    send_beat(32'h1234_5678, 4'hF);
    send_beat(32'h9ABC_DEF0, 4'hF);
    s32.valid = 1'b0;
    @(negedge clk_i);
    start = 1'b1;
    len_i = 16'd1;
    @(posedge clk_i);
    #1;
    start = 1'b0;
    chk("ign_start_busy", 64'(busy_o), 64'(1));
    chk("ign_start_cnt", 64'(beat_cnt_o), 64'(2));
    send_beat(32'h0F0F_0F0F, 4'b1010);
    send_beat(32'hCAFE_BABE, 4'hF);
    s32.valid = 1'b0;
    chk("ign_start_done", 64'(done_o), 64'(1));

    // enable low mid-run freezes count and LFSR
    force_ready = 1'b0;
    do_start(16'd6);
    for (int i = 0; i < 3; i++) send_beat(32'hA5A5_0000 + 32'(i), 4'hF);
    enable = 1'b0;
    s32.valid = 1'b1;
    s32.data  = 32'hDEAD_BEEF;
    c0 = beat_cnt_o;
    l0 = dut.lfsr_q;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      chk("en_hold_cnt", 64'(beat_cnt_o), 64'(c0));
      chk("en_hold_lfsr", 64'(dut.lfsr_q), 64'(l0));
    end
    enable = 1'b1;
    for (int i = 3; i < 6; i++) send_beat(32'hA5A5_0000 + 32'(i), 4'hF);
    s32.valid = 1'b0;
    chk("en_done", 64'(done_o), 64'(1));

    // random backpressure, source always valid
    do_start(16'd1000);
    run_cyc = 0;
    stall_cyc = 0;
    for (int i = 0; i < 1000; i++)
      send_beat((32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000, (i % 5 == 4) ? 4'b0110 : 4'hF);
    s32.valid = 1'b0;
    chk("bp_done", 64'(done_o), 64'(1));
    chk("bp_cnt", 64'(beat_cnt_o), 64'(1000));
    chk("bp_stall_lo", 64'(stall_cyc * 100 >= run_cyc * 45), 64'(1));
    chk("bp_stall_hi", 64'(stall_cyc * 100 <= run_cyc * 55), 64'(1));

    // forced ready: 1000 beats in 1000 cycles
    force_ready = 1'b1;
    do_start(16'd1000);
    run_cyc = 0;
    stall_cyc = 0;
    for (int i = 0; i < 1000; i++) send_beat(32'(i) ^ 32'h3C3C_3C3C, 4'hF);
    s32.valid = 1'b0;
    chk("fr_done", 64'(done_o), 64'(1));
    chk("fr_run_cycles", 64'(run_cyc), 64'(1000));
    chk("fr_stalls", 64'(stall_cyc), 64'(0));

    // clear at beat 5 of 20
    force_ready = 1'b0;
    do_start(16'd20);
    for (int i = 0; i < 5; i++) send_beat(32'h7777_0000 + 32'(i), 4'hF);
    s32.valid = 1'b0;
    clear = 1'b1;
    @(posedge clk_i);
    #1;
    clear = 1'b0;
    chk("clr_busy", 64'(busy_o), 64'(0));
    chk("clr_done", 64'(done_o), 64'(0));
    chk("clr_cnt", 64'(beat_cnt_o), 64'(0));
    chk("clr_sig", 64'(signature_o), 64'(0));
    chk("clr_err", 64'(strb_err_o), 64'(0));
    chk("clr_lfsr", 64'(dut.lfsr_q), 64'(16'hACE1));

    // wide data: 80-bit beats fold into three 32-bit chunks
    @(negedge clk_i);
    start_w = 1'b1;
    len_w   = 16'd2;
    @(posedge clk_i);
    #1;
    start_w = 1'b0;
    wide_beat(80'hABCD_0000_0000_0000_0000);
    chk("wide_sig1", 64'(sig_w), 64'(32'h0000_ABCD));
    wide_beat(80'h0000_89AB_CDEF_0123_4567);
    chk("wide_sig2", 64'(sig_w), 64'(32'h8889_DF12));
    chk("wide_cnt", 64'(cnt_w), 64'(2));
    chk("wide_done", 64'(done_w), 64'(1));
    chk("wide_err", 64'(err_w), 64'(0));

    repeat (2) @(posedge clk_i);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
